// File: rtl/oam_dma.sv
// OAM DMA engine: copies BYTES bytes from a source RAM page into 16-bit OAM words.
// Reads are issued one per step and paired into words as they return.
module oam_dma #(
    parameter int BYTES = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic [7:0]  src_page,
    output logic [15:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    output logic [6:0]  oam_addr,
    output logic        oam_write,
    output logic [15:0] oam_d_in,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] K_BYTES = 9'(BYTES);
    localparam logic [8:0] K_LAST  = 9'(BYTES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [8:0]  k_q, k_d;
    logic [7:0]  page_q, page_d;
    logic [15:0] src_addr_q, src_addr_d;
    logic        src_rd_q, src_rd_d;
    logic        arrive_q, arrive_d;
    logic [7:0]  buf0_q, buf0_d;
    logic [7:0]  buf1_q, buf1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic [6:0]  oam_addr_q, oam_addr_d;
    logic        oam_write_q, oam_write_d;
    logic [15:0] oam_d_in_q, oam_d_in_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [8:0]  k_next;
    logic        consume;
    logic [7:0]  cap_byte;

    // Returned bytes land in a 2-deep buffer (arrive_q marks src_data valid this clk),
    // so a step always finds byte k-2 whatever the ce spacing; bypass when empty.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        page_d      = page_q;
        src_addr_d  = src_addr_q;
        src_rd_d    = 1'b0;
        arrive_d    = src_rd_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        oam_addr_d  = oam_addr_q;
        oam_write_d = 1'b0;
        oam_d_in_d  = oam_d_in_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        k_next      = k_q + 9'd1;
        consume     = 1'b0;
        cap_byte    = (cnt_q != 2'd0) ? buf0_q : src_data;

        if (start) begin
            state_d    = RUN;
            k_d        = '0;
            page_d     = src_page;
            src_addr_d = {src_page, 8'h00};
            src_rd_d   = 1'b1;
            arrive_d   = 1'b0;
            cnt_d      = 2'd0;
            lo_d       = 8'h00;
            busy_d     = 1'b1;
        end else if (state_q == RUN) begin
            if (k_q == K_LAST) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else if (ce) begin
                k_d = k_next;
                if (k_next < K_BYTES) begin
                    src_addr_d = {page_q, k_next[7:0]};
                    src_rd_d   = 1'b1;
                end
                if (k_next >= 9'd2) begin
                    consume = 1'b1;
                    if (k_next[0]) begin
                        oam_write_d = 1'b1;
                        oam_addr_d  = k_next[7:1] - 7'd1;
                        oam_d_in_d  = {cap_byte, lo_q};
                    end else begin
                        lo_d = cap_byte;
                    end
                end
            end

            if (consume && (cnt_q != 2'd0)) begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            if (arrive_q && !(consume && (cnt_q == 2'd0))) begin
                if (cnt_d == 2'd0) begin
                    buf0_d = src_data;
                end else begin
                    buf1_d = src_data;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            page_q      <= '0;
            src_addr_q  <= '0;
            src_rd_q    <= 1'b0;
            arrive_q    <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            cnt_q       <= '0;
            lo_q        <= '0;
            oam_addr_q  <= '0;
            oam_write_q <= 1'b0;
            oam_d_in_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            page_q      <= page_d;
            src_addr_q  <= src_addr_d;
            src_rd_q    <= src_rd_d;
            arrive_q    <= arrive_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            oam_addr_q  <= oam_addr_d;
            oam_write_q <= oam_write_d;
            oam_d_in_q  <= oam_d_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign src_addr  = src_addr_q;
    assign src_rd    = src_rd_q;
    assign oam_addr  = oam_addr_q;
    assign oam_write = oam_write_q;
    assign oam_d_in  = oam_d_in_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a source RAM and OAM image, plus a step-level model that predicts
// every output each clock directly from the RAM contents.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        start;
    logic [7:0]  src_page;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data = 8'h00;
    logic [6:0]  oam_addr;
    logic        oam_write;
    logic [15:0] oam_d_in;
    logic        busy;
    logic        done;

    logic [7:0]  mem [0:65535];
    logic [15:0] oam [0:127];
    logic        oam_clear = 1'b0;

    int total = 0;
    int bad = 0;
    int write_cnt = 0;
    int done_cnt = 0;
    int ce_mode = 0;
    int ce_phase = 0;

    oam_dma #(.BYTES(160)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .start     (start),
        .src_page  (src_page),
        .src_addr  (src_addr),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .oam_addr  (oam_addr),
        .oam_write (oam_write),
        .oam_d_in  (oam_d_in),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (src_rd) src_data <= mem[src_addr];
    end

    always @(posedge clk) begin
        if (oam_clear) begin
            for (int i = 0; i < 128; i++) oam[i] <= 16'hDEAD;
        end else if (oam_write) begin
            oam[oam_addr] <= oam_d_in;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each edge is a reset, start, finishing clock, step or idle clock.
    logic        m_busy = 1'b0;
    logic        m_fin = 1'b0;
    int          m_k = 0;
    logic [7:0]  m_page = 8'h00;
    logic [15:0] e_src_addr = 16'h0;
    logic        e_src_rd = 1'b0;
    logic [6:0]  e_oam_addr = 7'h0;
    logic        e_write = 1'b0;
    logic [15:0] e_d_in = 16'h0;
    logic        e_done = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_fin = 1'b0; m_k = 0;
            e_src_addr = 16'h0; e_src_rd = 1'b0; e_oam_addr = 7'h0;
            e_write = 1'b0; e_d_in = 16'h0; e_done = 1'b0;
        end else begin
            e_src_rd = 1'b0; e_write = 1'b0; e_done = 1'b0;
            if (start) begin
                m_busy = 1'b1; m_fin = 1'b0; m_k = 0; m_page = src_page;
                e_src_addr = {src_page, 8'h00}; e_src_rd = 1'b1;
            end else if (m_busy && m_fin) begin
                m_busy = 1'b0; m_fin = 1'b0; e_done = 1'b1;
            end else if (m_busy && ce) begin
                m_k++;
                if (m_k < 160) begin
                    e_src_addr = {m_page, 8'(m_k)};
                    e_src_rd = 1'b1;
                end
                if (m_k >= 3 && (m_k % 2) == 1) begin
                    e_write = 1'b1;
                    e_oam_addr = 7'((m_k - 3) / 2);
                    e_d_in = {mem[{m_page, 8'(m_k - 2)}], mem[{m_page, 8'(m_k - 3)}]};
                end
                if (m_k == 161) m_fin = 1'b1;
            end
        end
        #1;
        check_output("src_addr", src_addr, e_src_addr);
        check_output("src_rd", src_rd, e_src_rd);
        check_output("oam_write", oam_write, e_write);
        check_output("busy", busy, m_busy);
        check_output("done", done, e_done);
        if (e_write) begin
            check_output("oam_addr", oam_addr, e_oam_addr);
            check_output("oam_d_in", oam_d_in, e_d_in);
        end
        if (oam_write) write_cnt++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        start = 1'b0;
        case (ce_mode)
            0: ce = 1'b1;
            1: ce = ((ce_phase % 4) == 3);
            2: ce = 1'($urandom_range(0, 1));
            default: ce = 1'b0;
        endcase
        ce_phase++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [7:0] page);
        start = 1'b1;
        src_page = page;
        tick();
    endtask

    task automatic clear_oam();
        oam_clear = 1'b1;
        tick();
        oam_clear = 1'b0;
    endtask

    task automatic wait_done(input int max_clks, output int clks);
        clks = 0;
        forever begin
            if (clks >= max_clks) begin
                total++;
                bad++;
                $display("[TB] FAIL done_timeout: got no done after %0d clks required done", clks);
                return;
            end
            tick();
            clks++;
            if (done) return;
        end
    endtask

    task automatic check_oam(input logic [7:0] page);
        for (int w = 0; w < 80; w++) begin
            check_output("oam_word", oam[w], {mem[{page, 8'(2 * w + 1)}], mem[{page, 8'(2 * w)}]});
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int clks;
        int w0;
        int d0;
        logic [15:0] a;
        logic [7:0] p;

        reset_n = 1'b0; start = 1'b0; ce = 1'b0; src_page = 8'h00;
        for (int i = 0; i < 65536; i++) begin
            a = 16'(i);
            if (a[15:8] == 8'hC0) mem[i] = a[7:0];
            else if (a[15:8] == 8'h80) mem[i] = a[7:0] ^ 8'hA5;
            else mem[i] = 8'($urandom);
        end
        repeat (3) @(negedge clk);
        check_output("rst_src_addr", src_addr, 16'h0000);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_src_rd", src_rd, 1'b0);
        check_output("rst_oam_d_in", oam_d_in, 16'h0000);
        reset_n = 1'b1;

        $display("[TB] basic transfer");
        ce_mode = 0;
        clear_oam();
        w0 = write_cnt;
        pulse_start(8'hC0);
        wait_done(400, clks);
        check_output("basic_latency", clks, 162);
        check_output("basic_writes", write_cnt - w0, 80);
        check_output("basic_busy_after", busy, 1'b0);
        check_output("basic_last_addr", src_addr, 16'hC09F);
        check_output("basic_word0", oam[0], 16'h0100);
        check_output("basic_word79", oam[79], 16'h9F9E);
        check_oam(8'hC0);

        $display("[TB] sparse ce");
        clear_oam();
        ce_mode = 1; ce_phase = 0;
        w0 = write_cnt;
        pulse_start(8'hC0);
        wait_done(1000, clks);
        check_output("sparse_writes", write_cnt - w0, 80);
        check_oam(8'hC0);

        $display("[TB] restart at step 50");
        ce_mode = 0;
        clear_oam();
        pulse_start(8'hC0);
        ticks(49);
        pulse_start(8'h80);
        wait_done(400, clks);
        check_output("restart_latency", clks, 162);
        check_oam(8'h80);

        $display("[TB] reset at step 30");
        pulse_start(8'hC0);
        ticks(29);
        w0 = write_cnt; d0 = done_cnt;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ticks(20);
        check_output("reset_writes", write_cnt - w0, 0);
        check_output("reset_dones", done_cnt - d0, 0);
        check_output("reset_busy", busy, 1'b0);
        clear_oam();
        pulse_start(8'hC0);
        wait_done(400, clks);
        check_output("after_reset_latency", clks, 162);
        check_oam(8'hC0);

        $display("[TB] start on final step");
        clear_oam();
        pulse_start(8'hC0);
        ticks(160);
        d0 = done_cnt;
        pulse_start(8'h80);
        wait_done(400, clks);
        check_output("final_start_latency", clks, 162);
        check_output("final_start_dones", done_cnt - d0, 1);
        check_oam(8'h80);

        $display("[TB] ce freeze at step 77");
        clear_oam();
        w0 = write_cnt;
        pulse_start(8'hC0);
        ticks(76);
        ce_mode = 3;
        ticks(20);
        check_output("freeze_addr", src_addr, 16'hC04D);
        check_output("freeze_busy", busy, 1'b1);
        ce_mode = 0;
        wait_done(400, clks);
        check_output("freeze_latency", 96 + clks, 182);
        check_output("freeze_writes", write_cnt - w0, 80);
        check_oam(8'hC0);

        $display("[TB] random transfers");
        ce_mode = 2;
        for (int t = 0; t < 8; t++) begin
            clear_oam();
            p = 8'($urandom);
            pulse_start(p);
            if ($urandom_range(0, 1) == 1) begin
                ticks($urandom_range(1, 300));
                p = 8'($urandom);
                pulse_start(p);
            end
            wait_done(3000, clks);
            check_oam(p);
        end

        ce_mode = 0;
        ticks(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
